// File: rtl/appmul_pkg.sv
// ============================================================================
// Module   : appmul_pkg
// Brief    : Shared types and constants for the approximate-multiplier controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package appmul_pkg;

    localparam int OP_W       = 16;
    localparam int PROD_W     = 32;
    localparam int NUM_LAYERS = 4;

    localparam logic [1:0] MODE_APPROX  = 2'b00;
    localparam logic [1:0] MODE_RECOVER = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAYER   = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage : appmul_pkg

`default_nettype wire

// File: rtl/appmul_pass_timer.sv
// ============================================================================
// Module   : appmul_pass_timer
// Brief    : DP_LAT-cycle down-counter; strobes on the last cycle of each pass
//            and reloads itself so consecutive passes run back to back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module appmul_pass_timer #(
    parameter int DP_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_last
);

    localparam int            C_CW     = 4;
    localparam logic [C_CW-1:0] C_RELOAD = C_CW'(DP_LAT - 1);

    logic [C_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= C_RELOAD;
        end else if (i_load) begin
            r_cnt <= C_RELOAD;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= C_RELOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_last = i_en && (r_cnt == '0);

endmodule : appmul_pass_timer

`default_nettype wire

// File: rtl/appmul_seq_ctrl.sv
// ============================================================================
// Module   : appmul_seq_ctrl
// Brief    : Sequences the shared reduction datapath through four layers and an
//            optional error-recovery pass, with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module appmul_seq_ctrl #(
    parameter int DP_LAT     = 2,
    parameter int NUM_LAYERS = appmul_pkg::NUM_LAYERS,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [appmul_pkg::OP_W-1:0]   in_a,
    input  logic [appmul_pkg::OP_W-1:0]   in_b,
    input  logic [1:0]                    in_mode,
    output logic [appmul_pkg::OP_W-1:0]   dp_a,
    output logic [appmul_pkg::OP_W-1:0]   dp_b,
    output logic                          dp_en,
    output logic [1:0]                    dp_layer,
    output logic                          dp_rec_en,
    input  logic [appmul_pkg::PROD_W-1:0] dp_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [appmul_pkg::PROD_W-1:0] out_data,
    output logic                          busy,
    output logic                          err_mode,
    output logic [CNT_W-1:0]              op_count
);

    import appmul_pkg::*;

    localparam logic [1:0] C_LAST_LAYER = 2'(NUM_LAYERS - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_rec;
    logic [1:0]          r_layer;
    logic [OP_W-1:0]     r_dp_a;
    logic [OP_W-1:0]     r_dp_b;
    logic                r_dp_en;
    logic                r_dp_rec_en;
    logic                r_out_valid;
    logic [PROD_W-1:0]   r_out_data;
    logic                r_err_mode;
    logic [CNT_W-1:0]    r_op_count;

    logic w_accept;
    logic w_pass_en;
    logic w_last;
    logic w_final_layer;
    logic w_capture;
    logic w_out_hs;

    assign w_accept      = (r_state == ST_IDLE) && in_valid;
    assign w_pass_en     = (r_state == ST_LAYER) || (r_state == ST_RECOVER);
    assign w_final_layer = (r_layer == C_LAST_LAYER);
    assign w_out_hs      = (r_state == ST_DONE) && out_ready;
    // The product is taken on the last cycle of whichever pass ends the op.
    assign w_capture     = w_last && (((r_state == ST_LAYER) && w_final_layer && !r_rec)
                                      || (r_state == ST_RECOVER));

    appmul_pass_timer #(
        .DP_LAT (DP_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_en   (w_pass_en),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nx = ST_LAYER;
                end
            end
            ST_LAYER: begin
                if (w_last && w_final_layer) begin
                    w_state_nx = r_rec ? ST_RECOVER : ST_DONE;
                end
            end
            ST_RECOVER: begin
                if (w_last) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath controls are registered off the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec       <= 1'b0;
            r_layer     <= 2'd0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_en     <= 1'b0;
            r_dp_rec_en <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err_mode  <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_dp_en     <= (w_state_nx == ST_LAYER) || (w_state_nx == ST_RECOVER);
            r_dp_rec_en <= (w_state_nx == ST_RECOVER);
            r_out_valid <= (w_state_nx == ST_DONE);

            if (w_accept) begin
                r_dp_a  <= in_a;
                r_dp_b  <= in_b;
                r_rec   <= (in_mode != MODE_APPROX);
                r_layer <= 2'd0;
                if (in_mode[1]) begin
                    r_err_mode <= 1'b1;
                end
            end else if ((r_state == ST_LAYER) && w_last && !w_final_layer) begin
                r_layer <= r_layer + 2'd1;
            end

            if (w_capture) begin
                r_out_data <= dp_result;
            end

            if (w_out_hs) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign dp_en     = r_dp_en;
    assign dp_layer  = r_layer;
    assign dp_rec_en = r_dp_rec_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err_mode  = r_err_mode;
    assign op_count  = r_op_count;

endmodule : appmul_seq_ctrl

`default_nettype wire

// File: tb/tb_appmul_seq_ctrl.sv
// ============================================================================
// Module   : tb_appmul_seq_ctrl
// Brief    : Scoreboard bench for appmul_seq_ctrl with a cycle-indexed datapath model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_appmul_seq_ctrl;

    localparam int C_L     = 2;
    localparam int C_CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        in_a = '0;
    logic [15:0]        in_b = '0;
    logic [1:0]         in_mode = '0;
    logic [15:0]        dp_a;
    logic [15:0]        dp_b;
    logic               dp_en;
    logic [1:0]         dp_layer;
    logic               dp_rec_en;
    logic [31:0]        dp_result;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_data;
    logic               busy;
    logic               err_mode;
    logic [C_CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side view of the op in flight.
    int                 cyc_since = 0;
    int                 cur_final = 0;
    logic               op_live   = 1'b0;
    logic [31:0]        cur_exp   = '0;
    logic [15:0]        cur_a     = '0;
    logic [15:0]        cur_b     = '0;
    logic               err_exp   = 1'b0;
    logic [C_CNT_W-1:0] exp_cnt   = '0;
    logic [31:0]        last_data = '0;
    logic [31:0]        sb_q[$];
    int                 run_lo    = 0;
    logic               chk_lo    = 1'b0;

    always #5 clk = ~clk;

    appmul_seq_ctrl #(
        .DP_LAT     (C_L),
        .NUM_LAYERS (4),
        .CNT_W      (C_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_en     (dp_en),
        .dp_layer  (dp_layer),
        .dp_rec_en (dp_rec_en),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .err_mode  (err_mode),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dp_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic rec);
        dp_model = (32'(a) * 32'(b)) ^ (rec ? 32'h0000_0001 : 32'h0);
    endfunction

    // Datapath returns the real product only on the final pass cycle.
    assign dp_result = (op_live && (cyc_since == cur_final)) ? cur_exp
                                                            : (32'hBAD0_0000 | 32'(cyc_since[15:0]));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_since <= 0;
            op_live   <= 1'b0;
            cur_a     <= '0;
            cur_b     <= '0;
            err_exp   <= 1'b0;
            exp_cnt   <= '0;
            sb_q.delete();
        end else begin
            cyc_since <= cyc_since + 1;
            if (in_valid && in_ready) begin
                cyc_since <= 0;
                op_live   <= 1'b1;
                cur_a     <= in_a;
                cur_b     <= in_b;
                cur_final <= ((in_mode != 2'b00) ? 5 : 4) * C_L - 1;
                cur_exp   <= dp_model(in_a, in_b, in_mode != 2'b00);
                sb_q.push_back(dp_model(in_a, in_b, in_mode != 2'b00));
                if (in_mode[1]) err_exp <= 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("sb_empty", 32'(sb_q.size() == 0), 32'd0);
                if (sb_q.size() != 0) begin
                    chk("sb_data", out_data, sb_q.pop_front());
                end
                chk("op_count_pre", 32'(op_count), 32'(exp_cnt));
                last_data <= out_data;
                op_live   <= 1'b0;
                exp_cnt   <= exp_cnt + 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("err_mode", 32'(err_mode), 32'(err_exp));
            chk("dp_a", 32'(dp_a), 32'(cur_a));
            chk("dp_b", 32'(dp_b), 32'(cur_b));
            chk("busy", 32'(busy), 32'(op_live));
            if (op_live) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                if (cyc_since <= cur_final) begin
                    chk("dp_en", 32'(dp_en), 32'd1);
                    chk("dp_layer", 32'(dp_layer), (cyc_since / C_L > 3) ? 32'd3 : 32'(cyc_since / C_L));
                    chk("dp_rec_en", 32'(dp_rec_en), 32'(cyc_since >= 4 * C_L));
                    chk("out_valid_early", 32'(out_valid), 32'd0);
                end else begin
                    chk("dp_en_done", 32'(dp_en), 32'd0);
                    chk("dp_rec_en_done", 32'(dp_rec_en), 32'd0);
                    chk("out_valid", 32'(out_valid), 32'd1);
                    chk("out_data", out_data, cur_exp);
                end
            end else begin
                chk("in_ready_idle", 32'(in_ready), 32'd1);
                chk("out_valid_idle", 32'(out_valid), 32'd0);
                chk("dp_en_idle", 32'(dp_en), 32'd0);
            end
            if (!in_ready) begin
                run_lo = run_lo + 1;
            end else begin
                if (chk_lo && run_lo != 0) chk("rdy_lo_len", 32'(run_lo), 32'(4 * C_L + 1));
                run_lo = 0;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((op_live || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(op_live), 32'd0);
    endtask

    initial begin
        logic [C_CNT_W-1:0] cnt_before;
        int n;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_dp_ab", {dp_a, dp_b}, 32'd0);
        chk("rst_dp_ctl", {29'd0, dp_en, dp_rec_en, busy}, 32'd0);
        chk("rst_layer", 32'(dp_layer), 32'd0);
        chk("rst_cnt_err", {27'd0, err_mode, op_count}, 32'd0);
        rst = 1'b0;

        send(16'h00FF, 16'h0101, 2'b00);
        wait_idle();
        chk("approx_data", last_data, 32'h0000_FFFF);

        send(16'h1234, 16'hABCD, 2'b01);
        wait_idle();
        chk("rec_data", last_data, dp_model(16'h1234, 16'hABCD, 1'b1));

        out_ready = 1'b0;
        send(16'h0F0F, 16'h3003, 2'b00);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_a     = $urandom;
            in_b     = $urandom;
        end
        cnt_before = op_count;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_count_inc", 32'(op_count), 32'(cnt_before + 1'b1));
        wait_idle();

        send(16'h0042, 16'h0077, 2'b10);
        wait_idle();
        chk("err_mode_set", 32'(err_mode), 32'd1);
        send(16'h0003, 16'h0005, 2'b00);
        wait_idle();
        chk("err_mode_sticky", 32'(err_mode), 32'd1);

        send(16'hBEEF, 16'h0002, 2'b01);
        n = 0;
        while (cyc_since != 4 * C_L + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rec_reached", 32'(dp_rec_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_outs", {28'd0, out_valid, dp_en, dp_rec_en, busy}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_ab", {dp_a, dp_b}, 32'd0);
        chk("mid_rst_layer", 32'(dp_layer), 32'd0);
        chk("mid_rst_cnt_err", {27'd0, err_mode, op_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        chk_lo = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(16'($urandom), 16'($urandom), 2'b00);
        end
        wait_idle();
        chk_lo = 1'b0;
        chk("wrap_count", 32'(op_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_appmul_seq_ctrl

`default_nettype wire
